// File: rtl/pixel_readout_rx_if.sv
// Row output port of the pixel readout receiver: one assembled row
// (all columns, lines A and B) with its row index, valid/ready handshake.
interface pixel_readout_rx_if #(
    parameter int Row  = 2,
    parameter int Col  = 2,
    parameter int CntW = 4
) ();
    localparam int IdxW = (Row > 1) ? $clog2(Row) : 1;

    logic [2*Col*CntW-1:0] rowData;
    logic [IdxW-1:0]       rowIdx;
    logic                  rowValid;
    logic                  rowReady;

    // Receiver side: produces rows
    modport master (
        output rowData,
        output rowIdx,
        output rowValid,
        input  rowReady
    );

    // Consumer side: periphery readout FIFO
    modport slave (
        input  rowData,
        input  rowIdx,
        input  rowValid,
        output rowReady
    );
endinterface

// File: rtl/pixel_readout_rx.sv
// Pixel-array serial readout receiver. Deserializes lines A and B of every
// column chain in parallel, MSB first, and hands out one complete row every
// CntW readClk edges through a single-entry holding register. Rows that
// complete while the holding register is full and stalled are dropped and
// flagged with a sticky overflow bit.
module pixel_readout_rx #(
    parameter int Row  = 2,
    parameter int Col  = 2,
    parameter int CntW = 4
) (
    input  logic                  readClk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [Col-1:0]        serOutA,
    input  logic [Col-1:0]        serOutB,
    pixel_readout_rx_if.master    row_if,
    output logic                  busy,
    output logic                  frameDone,
    output logic                  overflow
);
    localparam int IdxW = (Row > 1) ? $clog2(Row) : 1;
    localparam int BitW = (CntW > 1) ? $clog2(CntW) : 1;

    typedef enum logic [0:0] {
        IDLE,
        SHIFT
    } state_t;

    state_t state, state_nxt;

    logic [BitW-1:0] bit_cnt;
    logic [IdxW-1:0] row_cnt;

    // Only the CntW-1 older bits need storage: the newest bit comes straight
    // from the serial input on the row-complete edge.
    logic [Col-1:0][CntW-2:0] sh_a, sh_b;
    logic [Col-1:0][CntW-1:0] nxt_a, nxt_b;

    logic row_done, last_row, load, drop;

    // Per-column shift value including the bit sampled on this edge
    for (genvar c = 0; c < Col; c++) begin : g_col
        assign nxt_a[c] = {sh_a[c], serOutA[c]};
        assign nxt_b[c] = {sh_b[c], serOutB[c]};
    end

    // Holding register: refill when empty or draining this edge, else drop
    assign load = row_done & (~row_if.rowValid | row_if.rowReady);
    assign drop = row_done & row_if.rowValid & ~row_if.rowReady;

    // FSM state register
    always_ff @(posedge readClk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next-state and row/frame boundary decode
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        row_done  = 1'b0;
        last_row  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = SHIFT;
            end
            SHIFT: begin
                busy     = 1'b1;
                row_done = (bit_cnt == BitW'(CntW - 1));
                last_row = (row_cnt == IdxW'(Row - 1));
                if (row_done && last_row) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counters, shift registers, holding register and status flags
    always_ff @(posedge readClk) begin
        if (reset) begin
            bit_cnt         <= '0;
            row_cnt         <= '0;
            sh_a            <= '0;
            sh_b            <= '0;
            row_if.rowData  <= '0;
            row_if.rowIdx   <= '0;
            row_if.rowValid <= 1'b0;
            frameDone       <= 1'b0;
            overflow        <= 1'b0;
        end else begin
            frameDone <= row_done & last_row;

            if (state == IDLE && start) begin
                bit_cnt  <= '0;
                row_cnt  <= '0;
                overflow <= 1'b0;
            end

            if (state == SHIFT) begin
                for (int c = 0; c < Col; c++) begin
                    sh_a[c] <= nxt_a[c][CntW-2:0];
                    sh_b[c] <= nxt_b[c][CntW-2:0];
                end
                if (row_done) begin
                    bit_cnt <= '0;
                    row_cnt <= last_row ? '0 : row_cnt + IdxW'(1);
                end else begin
                    bit_cnt <= bit_cnt + BitW'(1);
                end
            end

            if (load) begin
                row_if.rowData  <= {nxt_b, nxt_a};
                row_if.rowIdx   <= row_cnt;
                row_if.rowValid <= 1'b1;
            end else if (row_if.rowValid && row_if.rowReady) begin
                row_if.rowValid <= 1'b0;
            end

            if (drop) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pixel_readout_rx.sv
// Directed-sequence bench for pixel_readout_rx with random pixel values.
// Expected rows come from a per-pixel value table packed into row words;
// a monitor logs every accepted row for comparison.
module tb_pixel_readout_rx;
    localparam int ROW = 2;
    localparam int COL = 2;
    localparam int CW  = 4;
    localparam int DW  = 2*COL*CW;

    logic           readClk = 1'b0;
    logic           reset, start;
    logic [COL-1:0] serOutA, serOutB;
    logic           busy, frameDone, overflow;

    pixel_readout_rx_if #(.Row(ROW), .Col(COL), .CntW(CW)) bus ();

    pixel_readout_rx #(.Row(ROW), .Col(COL), .CntW(CW)) dut (
        .readClk   (readClk),
        .reset     (reset),
        .start     (start),
        .serOutA   (serOutA),
        .serOutB   (serOutB),
        .row_if    (bus),
        .busy      (busy),
        .frameDone (frameDone),
        .overflow  (overflow)
    );

    always #5 readClk = ~readClk;

    int total = 0;
    int bad   = 0;
    int rd    = 0;
    int fd_cnt   = 0;
    int busy_cnt = 0;
    logic [CW-1:0]  pa [ROW][COL];
    logic [CW-1:0]  pb [ROW][COL];
    logic [DW-1:0]  got_d [$];
    int             got_i [$];

    // Consumer-side monitor: every handshake outside reset is one delivered row
    always @(posedge readClk) begin
        if (!reset) begin
            if (bus.rowValid && bus.rowReady) begin
                got_d.push_back(bus.rowData);
                got_i.push_back(int'(bus.rowIdx));
            end
            if (busy)      busy_cnt++;
            if (frameDone) fd_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Row word as the consumer sees it: {B[Col-1]..B[0], A[Col-1]..A[0]}
    function automatic logic [DW-1:0] row_word(input int r);
        logic [DW-1:0] w;
        w = '0;
        for (int c = 0; c < COL; c++) begin
            w[c*CW +: CW]         = pa[r][c];
            w[(COL+c)*CW +: CW]   = pb[r][c];
        end
        return w;
    endfunction

    task automatic rand_frame();
        for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++) begin
                pa[r][c] = CW'($urandom_range(0, (1 << CW) - 1));
                pb[r][c] = CW'($urandom_range(0, (1 << CW) - 1));
            end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge readClk);
    endtask

    // Compare the next n delivered rows against rows first..first+n-1
    task automatic chk_rows(input string tag, input int first, input int n);
        logic [DW-1:0] d;
        int            ix;
        chk({tag, "_count"}, 64'(got_d.size() - rd), 64'(n));
        for (int j = 0; j < n; j++) begin
            d  = (rd < got_d.size()) ? got_d[rd] : 'x;
            ix = (rd < got_i.size()) ? got_i[rd] : -1;
            chk({tag, "_data"}, 64'(d), 64'(row_word(first + j)));
            chk({tag, "_idx"}, 64'(ix), 64'(first + j));
            rd++;
        end
    endtask

    // One frame. mode: 0 never ready, 1 always ready, 2 ready only on the
    // last edge. rst_edge>0 asserts reset on that SHIFT edge and aborts.
    task automatic send_frame(input int mode, input int rst_edge, input bit extra_start);
        int r, k;
        start    = 1'b1;
        bus.rowReady = (mode == 1);
        @(negedge readClk);
        start = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_ovf_clr", 64'(overflow), 64'd0);
        for (int i = 1; i <= ROW*CW; i++) begin
            r = (i - 1) / CW;
            k = (i - 1) % CW;
            for (int c = 0; c < COL; c++) begin
                serOutA[c] = pa[r][c][CW-1-k];
                serOutB[c] = pb[r][c][CW-1-k];
            end
            bus.rowReady = (mode == 1) || (mode == 2 && i == ROW*CW);
            start = extra_start && (i == 3 || i == 6);
            reset = (i == rst_edge);
            @(negedge readClk);
            if (i == rst_edge) begin
                reset = 1'b0;
                start = 1'b0;
                return;
            end
        end
        start = 1'b0;
        chk("frame_done_pulse", 64'(frameDone), 64'd1);
        chk("busy_after_frame", 64'(busy), 64'd0);
        if (mode != 1) bus.rowReady = 1'b0;
    endtask

    initial begin
        int fd0, b0;
        reset        = 1'b1;
        start        = 1'b1;
        bus.rowReady = 1'b0;
        serOutA      = '0;
        serOutB      = '0;

        // 1: reset held 3 cycles with start high and noisy serial inputs
        for (int i = 0; i < 3; i++) begin
            serOutA = COL'($urandom);
            serOutB = COL'($urandom);
            @(negedge readClk);
            chk("rst_busy", 64'(busy), 64'd0);
        end
        chk("rst_rowValid", 64'(bus.rowValid), 64'd0);
        chk("rst_rowData", 64'(bus.rowData), 64'd0);
        chk("rst_rowIdx", 64'(bus.rowIdx), 64'd0);
        chk("rst_frameDone", 64'(frameDone), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        reset   = 1'b0;
        start   = 1'b0;
        serOutA = '0;
        serOutB = '0;
        idle(2);
        chk("idle_busy", 64'(busy), 64'd0);

        // 2: fixed frame, consumer always ready
        pa[0][0] = 4'b1010; pa[0][1] = 4'b0011; pb[0][0] = 4'b1111; pb[0][1] = 4'b0001;
        pa[1][0] = 4'b0101; pa[1][1] = 4'b1100; pb[1][0] = 4'b0000; pb[1][1] = 4'b1000;
        fd0 = fd_cnt; b0 = busy_cnt;
        send_frame(1, 0, 1'b0);
        idle(2);
        chk("t2_count", 64'(got_d.size() - rd), 64'd2);
        chk("t2_row0", 64'((rd < got_d.size()) ? got_d[rd] : 'x), 64'h1F3A);
        chk("t2_idx0", 64'((rd < got_i.size()) ? got_i[rd] : -1), 64'd0);
        chk("t2_row1", 64'((rd + 1 < got_d.size()) ? got_d[rd+1] : 'x), 64'h80C5);
        chk("t2_idx1", 64'((rd + 1 < got_i.size()) ? got_i[rd+1] : -1), 64'd1);
        rd = got_d.size();
        chk("t2_busy_cycles", 64'(busy_cnt - b0), 64'd8);
        chk("t2_fd_pulses", 64'(fd_cnt - fd0), 64'd1);

        // 3: consumer stalled for the whole frame
        rand_frame();
        send_frame(0, 0, 1'b0);
        chk("t3_held_valid", 64'(bus.rowValid), 64'd1);
        chk("t3_held_data", 64'(bus.rowData), 64'(row_word(0)));
        chk("t3_held_idx", 64'(bus.rowIdx), 64'd0);
        chk("t3_overflow", 64'(overflow), 64'd1);
        chk("t3_none_taken", 64'(got_d.size() - rd), 64'd0);
        bus.rowReady = 1'b1;
        idle(3);
        chk_rows("t3_drain", 0, 1);
        chk("t3_valid_clr", 64'(bus.rowValid), 64'd0);
        chk("t3_overflow_sticky", 64'(overflow), 64'd1);

        // 4: ready only on row1's completion edge
        rand_frame();
        send_frame(2, 0, 1'b0);
        chk_rows("t4_row0", 0, 1);
        chk("t4_valid", 64'(bus.rowValid), 64'd1);
        chk("t4_data", 64'(bus.rowData), 64'(row_word(1)));
        chk("t4_idx", 64'(bus.rowIdx), 64'd1);
        chk("t4_overflow", 64'(overflow), 64'd0);
        bus.rowReady = 1'b1;
        idle(2);
        chk_rows("t4_row1", 1, 1);

        // 5: reset on the 5th SHIFT edge, then a clean frame
        rand_frame();
        fd0 = fd_cnt;
        send_frame(1, 5, 1'b0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_valid", 64'(bus.rowValid), 64'd0);
        idle(3);
        chk("t5_no_fd", 64'(fd_cnt - fd0), 64'd0);
        chk("t5_no_rows", 64'(got_d.size() - rd), 64'd0);
        rand_frame();
        send_frame(1, 0, 1'b0);
        idle(2);
        chk_rows("t5_frame", 0, 2);

        // 6: start pulses mid-frame ignored, then back-to-back frame
        rand_frame();
        fd0 = fd_cnt; b0 = busy_cnt;
        send_frame(1, 0, 1'b1);
        idle(1);
        chk_rows("t6_frame_a", 0, 2);
        rand_frame();
        send_frame(1, 0, 1'b0);
        idle(2);
        chk_rows("t6_frame_b", 0, 2);
        chk("t6_busy_cycles", 64'(busy_cnt - b0), 64'd16);
        chk("t6_fd_pulses", 64'(fd_cnt - fd0), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
